// File: rtl/wb_pkg.sv
// Shared types and helpers for the register-file writeback controller.
package wb_pkg;
   localparam int XLEN       = 32;
   localparam int REG_ADDR_W = 5;

   typedef struct packed {
      logic [REG_ADDR_W-1:0] rd;
      logic [XLEN-1:0]       data;
   } wb_req_t;

   function automatic logic is_x0(input logic [REG_ADDR_W-1:0] r);
      return r == '0;
   endfunction
endpackage

// File: rtl/wb_load_queue.sv
// Synchronous FIFO of load responses awaiting a register-file write slot.
// DEPTH must be a power of two so the pointers wrap naturally.
module wb_load_queue
   import wb_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       push,
   input  wb_req_t                    push_req,
   input  logic                       pop,
   output wb_req_t                    head,
   output logic [$clog2(DEPTH+1)-1:0] count,
   output logic                       full,
   output logic                       empty
);
   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = $clog2(DEPTH+1);

   wb_req_t            mem [DEPTH];
   logic [PTR_W-1:0]   wr_ptr;
   logic [PTR_W-1:0]   rd_ptr;
   logic               do_push;
   logic               do_pop;

   assign full    = (count == CNT_W'(DEPTH));
   assign empty   = (count == '0);
   assign do_push = push & ~full;
   assign do_pop  = pop & ~empty;
   assign head    = mem[rd_ptr];

   // Storage carries no reset; only pointers and count define validity.
   always_ff @(posedge clk) begin
      if (do_push) begin
         mem[wr_ptr] <= push_req;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) begin
            wr_ptr <= wr_ptr + PTR_W'(1);
         end
         if (do_pop) begin
            rd_ptr <= rd_ptr + PTR_W'(1);
         end
         case ({do_push, do_pop})
            2'b10:   count <= count + CNT_W'(1);
            2'b01:   count <= count - CNT_W'(1);
            default: count <= count;
         endcase
      end
   end
endmodule

// File: rtl/regfile_writeback.sv
// Write-side controller for the 32x32 register file: merges ALU results with queued loads
// and tracks outstanding loads. Optional macro WB_LQ_PRIORITY_EN lets a full queue preempt the ALU.
module regfile_writeback #(
   parameter int XLEN     = 32,
   parameter int LQ_DEPTH = 4
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          alu_valid,
   input  logic [4:0]                    alu_rd,
   input  logic [XLEN-1:0]               alu_data,
   input  logic                          ld_issue,
   input  logic [4:0]                    ld_issue_rd,
   input  logic                          ld_valid,
   input  logic [4:0]                    ld_rd,
   input  logic [XLEN-1:0]               ld_data,
   output logic                          ld_ready,
   output logic                          write_en,
   output logic [4:0]                    rd,
   output logic [XLEN-1:0]               write_data,
   output logic [31:0]                   pending,
   output logic [$clog2(LQ_DEPTH+1)-1:0] lq_count,
   output logic                          alu_stall,
   output logic                          wb_err
);
   import wb_pkg::*;

   wb_req_t     push_req;
   wb_req_t     head;
   logic        push;
   logic        pop;
   logic        full;
   logic        empty;
   logic        stall;
   logic        alu_win;
   logic        err_now;
   logic [31:0] pending_nxt;

   wb_load_queue #(.DEPTH(LQ_DEPTH)) u_lq (
      .clk      (clk),
      .rst      (rst),
      .push     (push),
      .push_req (push_req),
      .pop      (pop),
      .head     (head),
      .count    (lq_count),
      .full     (full),
      .empty    (empty)
   );

   assign ld_ready = ~full;
   assign push     = ld_valid & ld_ready;
   assign push_req = '{rd: ld_rd, data: ld_data};

`ifdef WB_LQ_PRIORITY_EN
   assign stall = full;
`else
   assign stall = 1'b0;
`endif
   assign alu_stall = stall;

   // The queue only gets the port when the ALU has nothing real to write.
   assign alu_win = alu_valid & ~is_x0(alu_rd) & ~stall;
   assign pop     = ~alu_win & ~empty;

   always_comb begin
      pending_nxt = pending;
      if (pop) begin
         pending_nxt[head.rd] = 1'b0;
      end
      if (ld_issue && !is_x0(ld_issue_rd)) begin
         pending_nxt[ld_issue_rd] = 1'b1;
      end
   end

   // A discarded x0 load was never tracked, so its dequeue is not an error.
   always_comb begin
      err_now = 1'b0;
      if (ld_valid && !ld_ready) begin
         err_now = 1'b1;
      end
      if (ld_issue && !is_x0(ld_issue_rd) && pending[ld_issue_rd]) begin
         err_now = 1'b1;
      end
      if (alu_win && pending[alu_rd]) begin
         err_now = 1'b1;
      end
      if (pop && !is_x0(head.rd) && !pending[head.rd]) begin
         err_now = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         write_en   <= 1'b0;
         rd         <= '0;
         write_data <= '0;
         pending    <= '0;
         wb_err     <= 1'b0;
      end else begin
         pending <= pending_nxt;
         if (err_now) begin
            wb_err <= 1'b1;
         end
         if (alu_win) begin
            write_en   <= 1'b1;
            rd         <= alu_rd;
            write_data <= alu_data;
         end else if (pop && !is_x0(head.rd)) begin
            write_en   <= 1'b1;
            rd         <= head.rd;
            write_data <= head.data;
         end else begin
            write_en <= 1'b0;
         end
      end
   end
endmodule

// File: tb/tb_regfile_writeback.sv
// Self-checking bench for regfile_writeback: directed vector table, corner sequences, random vs. queue model.
module tb_regfile_writeback;
   localparam int LQ_DEPTH = 4;
`ifdef WB_LQ_PRIORITY_EN
   localparam bit PRIO = 1'b1;
`else
   localparam bit PRIO = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst;
   logic        alu_valid;
   logic [4:0]  alu_rd;
   logic [31:0] alu_data;
   logic        ld_issue;
   logic [4:0]  ld_issue_rd;
   logic        ld_valid;
   logic [4:0]  ld_rd;
   logic [31:0] ld_data;
   logic        ld_ready;
   logic        write_en;
   logic [4:0]  rd;
   logic [31:0] write_data;
   logic [31:0] pending;
   logic [2:0]  lq_count;
   logic        alu_stall;
   logic        wb_err;

   int n_checks = 0;
   int n_fail   = 0;

   regfile_writeback #(.XLEN(32), .LQ_DEPTH(LQ_DEPTH)) dut (
      .clk(clk), .rst(rst),
      .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data),
      .ld_issue(ld_issue), .ld_issue_rd(ld_issue_rd),
      .ld_valid(ld_valid), .ld_rd(ld_rd), .ld_data(ld_data),
      .ld_ready(ld_ready), .write_en(write_en), .rd(rd), .write_data(write_data),
      .pending(pending), .lq_count(lq_count), .alu_stall(alu_stall), .wb_err(wb_err)
   );

   always #5 clk = ~clk;

   // Reference model: a plain queue of responses plus a pending bitmap.
   typedef struct packed {
      logic [4:0]  rd;
      logic [31:0] data;
   } ent_t;

   ent_t        mq[$];
   logic [31:0] m_pend;
   logic        m_err;
   logic        m_we;
   logic [4:0]  m_rd;
   logic [31:0] m_data;
   int          outst[$];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      mq.delete();
      outst.delete();
      m_pend = '0;
      m_err  = 1'b0;
      m_we   = 1'b0;
      m_rd   = '0;
      m_data = '0;
   endtask

   task automatic model_step();
      int          n     = mq.size();
      bit          ready = (n < LQ_DEPTH);
      bit          stall = PRIO && (n == LQ_DEPTH);
      bit          alu_w = alu_valid && (alu_rd != 0) && !stall;
      logic [31:0] np    = m_pend;
      ent_t        h;
      if (ld_valid && !ready) m_err = 1'b1;
      if (ld_issue && ld_issue_rd != 0 && m_pend[ld_issue_rd]) m_err = 1'b1;
      if (alu_w && m_pend[alu_rd]) m_err = 1'b1;
      m_we = 1'b0;
      if (alu_w) begin
         m_we   = 1'b1;
         m_rd   = alu_rd;
         m_data = alu_data;
      end else if (n > 0) begin
         h = mq.pop_front();
         if (h.rd != 0 && !m_pend[h.rd]) m_err = 1'b1;
         np[h.rd] = 1'b0;
         if (h.rd != 0) begin
            m_we   = 1'b1;
            m_rd   = h.rd;
            m_data = h.data;
         end
      end
      if (ld_issue && ld_issue_rd != 0) np[ld_issue_rd] = 1'b1;
      m_pend = np;
      if (ld_valid && ready) mq.push_back('{rd: ld_rd, data: ld_data});
   endtask

   task automatic check_all();
      chk("write_en",   32'(write_en),   32'(m_we));
      chk("rd",         32'(rd),         32'(m_rd));
      chk("write_data", write_data,      m_data);
      chk("pending",    pending,         m_pend);
      chk("lq_count",   32'(lq_count),   32'(mq.size()));
      chk("ld_ready",   32'(ld_ready),   32'(mq.size() < LQ_DEPTH));
      chk("alu_stall",  32'(alu_stall),  32'(PRIO && mq.size() == LQ_DEPTH));
      chk("wb_err",     32'(wb_err),     32'(m_err));
   endtask

   task automatic set_idle();
      alu_valid = 0; alu_rd = 0; alu_data = 0;
      ld_issue = 0; ld_issue_rd = 0;
      ld_valid = 0; ld_rd = 0; ld_data = 0;
   endtask

   task automatic drive(input logic av, input logic [4:0] ard, input logic [31:0] adata,
                        input logic li, input logic [4:0] lird,
                        input logic lv, input logic [4:0] lrd, input logic [31:0] ldata);
      alu_valid = av; alu_rd = ard; alu_data = adata;
      ld_issue = li; ld_issue_rd = lird;
      ld_valid = lv; ld_rd = lrd; ld_data = ldata;
   endtask

   // Inputs change just after a falling edge; outputs are checked on the following falling edge.
   task automatic tick();
      model_step();
      @(posedge clk);
      @(negedge clk);
      check_all();
   endtask

   task automatic do_reset();
      set_idle();
      rst = 1'b0;
      #2;
      model_reset();
      check_all();
      @(negedge clk);
      rst = 1'b1;
   endtask

   typedef struct {
      logic        av;   logic [4:0] ard;  logic [31:0] adata;
      logic        li;   logic [4:0] lird;
      logic        lv;   logic [4:0] lrd;  logic [31:0] ldata;
      logic        we;   logic [4:0] erd;  logic [31:0] edata;
      int          cnt;  logic [31:0] pend; logic err;
   } vec_t;

   vec_t tbl[13];

   initial begin
      int r;
      int idx;

      tbl[0]  = '{1, 5, 32'hDEADBEEF, 0, 0, 0, 0, 0,        1, 5, 32'hDEADBEEF, 0, 32'h0,   0};
      tbl[1]  = '{1, 0, 32'h00000001, 0, 0, 0, 0, 0,        0, 5, 32'hDEADBEEF, 0, 32'h0,   0};
      tbl[2]  = '{0, 0, 0,            1, 7, 0, 0, 0,        0, 5, 32'hDEADBEEF, 0, 32'h80,  0};
      tbl[3]  = '{0, 0, 0,            0, 0, 1, 7, 32'h1234, 0, 5, 32'hDEADBEEF, 1, 32'h80,  0};
      tbl[4]  = '{0, 0, 0,            0, 0, 0, 0, 0,        1, 7, 32'h1234,     0, 32'h0,   0};
      tbl[5]  = '{0, 0, 0,            1, 9, 0, 0, 0,        0, 7, 32'h1234,     0, 32'h200, 0};
      tbl[6]  = '{0, 0, 0,            0, 0, 1, 9, 32'h99,   0, 7, 32'h1234,     1, 32'h200, 0};
      tbl[7]  = '{1, 3, 32'h33,       0, 0, 0, 0, 0,        1, 3, 32'h33,       1, 32'h200, 0};
      tbl[8]  = '{0, 0, 0,            0, 0, 0, 0, 0,        1, 9, 32'h99,       0, 32'h0,   0};
      tbl[9]  = '{0, 0, 0,            1, 4, 0, 0, 0,        0, 9, 32'h99,       0, 32'h10,  0};
      tbl[10] = '{0, 0, 0,            0, 0, 1, 4, 32'h44,   0, 9, 32'h99,       1, 32'h10,  0};
      tbl[11] = '{0, 0, 0,            1, 4, 0, 0, 0,        1, 4, 32'h44,       0, 32'h10,  1};
      tbl[12] = '{0, 0, 0,            0, 0, 0, 0, 0,        0, 4, 32'h44,       0, 32'h10,  1};

      set_idle();
      rst = 1'b0;
      model_reset();
      repeat (2) @(negedge clk);
      check_all();
      rst = 1'b1;

      for (int i = 0; i < 13; i++) begin
         drive(tbl[i].av, tbl[i].ard, tbl[i].adata, tbl[i].li, tbl[i].lird,
               tbl[i].lv, tbl[i].lrd, tbl[i].ldata);
         tick();
         chk($sformatf("tbl%0d_we", i),   32'(write_en), 32'(tbl[i].we));
         chk($sformatf("tbl%0d_rd", i),   32'(rd),       32'(tbl[i].erd));
         chk($sformatf("tbl%0d_data", i), write_data,    tbl[i].edata);
         chk($sformatf("tbl%0d_cnt", i),  32'(lq_count), 32'(tbl[i].cnt));
         chk($sformatf("tbl%0d_pend", i), pending,       tbl[i].pend);
         chk($sformatf("tbl%0d_err", i),  32'(wb_err),   32'(tbl[i].err));
      end
      set_idle();

      // Reset with three responses waiting behind continuous ALU traffic.
      do_reset();
      for (int i = 0; i < 3; i++) begin
         drive(0, 0, 0, 1, 5'(10 + i), 0, 0, 0);
         tick();
      end
      for (int i = 0; i < 3; i++) begin
         drive(1, 1, 32'(i), 0, 0, 1, 5'(10 + i), 32'(32'hC0 + i));
         tick();
      end
      chk("midq_count_before", 32'(lq_count), 32'd3);
      do_reset();
      chk("midq_count", 32'(lq_count), 32'd0);
      chk("midq_pending", pending, 32'd0);
      chk("midq_ld_ready", 32'(ld_ready), 32'd1);

      // Fill the queue under ALU traffic, then offer one response too many.
      do_reset();
      for (int i = 1; i <= 4; i++) begin
         drive(0, 0, 0, 1, 5'(i), 0, 0, 0);
         tick();
      end
      for (int i = 0; i < 4; i++) begin
         drive(1, 20, 32'(100 + i), 0, 0, 1, 5'(1 + i), 32'(32'hA0 + i));
         tick();
      end
      chk("full_count", 32'(lq_count), 32'd4);
      chk("full_ld_ready", 32'(ld_ready), 32'd0);
      chk("full_alu_stall", 32'(alu_stall), 32'(PRIO));
      drive(1, 20, 32'h55, 0, 0, 1, 5, 32'h5);
      tick();
      chk("overflow_err", 32'(wb_err), 32'd1);
`ifdef WB_LQ_PRIORITY_EN
      chk("prio_head_rd", 32'(rd), 32'd1);
      chk("prio_head_data", write_data, 32'hA0);
      chk("prio_count", 32'(lq_count), 32'd3);
`else
      chk("alu_wins_rd", 32'(rd), 32'd20);
      chk("alu_wins_count", 32'(lq_count), 32'd4);
`endif
      set_idle();
      for (int i = 0; i < 6; i++) tick();
      chk("err_sticky", 32'(wb_err), 32'd1);
      chk("drained", 32'(lq_count), 32'd0);

      // Well-behaved random traffic: no errors expected.
      do_reset();
      for (int c = 0; c < 1500; c++) begin
         set_idle();
         if (outst.size() > 0 && mq.size() < LQ_DEPTH && $urandom_range(0, 9) < 4) begin
            idx = $urandom_range(0, outst.size() - 1);
            ld_valid = 1; ld_rd = 5'(outst[idx]); ld_data = $urandom;
            outst.delete(idx);
         end
         if ($urandom_range(0, 9) < 3) begin
            r = $urandom_range(1, 31);
            if (!m_pend[r]) begin
               ld_issue = 1; ld_issue_rd = 5'(r);
               outst.push_back(r);
            end
         end
         if ($urandom_range(0, 1) == 1) begin
            r = $urandom_range(0, 31);
            if (!m_pend[r]) begin
               alu_valid = 1; alu_rd = 5'(r); alu_data = $urandom;
            end
         end
         tick();
      end
      set_idle();
      chk("random_no_err", 32'(wb_err), 32'd0);

      // Unconstrained random traffic, including protocol violations and x0 loads.
      do_reset();
      for (int c = 0; c < 300; c++) begin
         drive(1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)), $urandom,
               1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)),
               1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)), $urandom);
         tick();
      end
      set_idle();
      for (int i = 0; i < 6; i++) tick();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
